// File: rtl/uart_tx_cfg_if.sv
// Host-side handshake between the UART register file and the uart_tx_cfg serialiser.
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_busy;
  logic                 tx_full;
  logic                 tx_end;

  modport master (output tx_start, tx_data, input tx_busy, tx_full, tx_end);
  modport slave  (input tx_start, tx_data, output tx_busy, tx_full, tx_end);
endinterface

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter (divisor, parity, 1/2 stop bits latched per frame).
// Define UART_TX_FIFO_EN to put a FIFO_DEPTH-entry TX FIFO in front of the serialiser.
module uart_tx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic                 cfg_par_en,
  input  logic                 cfg_par_odd,
  input  logic                 cfg_stop2,
  uart_tx_cfg_if.slave         bus,
  output logic                 tx
);
  localparam int CW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_bits
    $error("uart_tx_cfg: DATA_BITS out of range");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("uart_tx_cfg: FIFO_DEPTH must be a power of two >= 2");
  end

  state_t                state_q, state_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [DIV_WIDTH-1:0]  div_l_q, div_l_d;
  logic [CW-1:0]         bit_q, bit_d;
  logic [DATA_BITS-1:0]  sh_q, sh_d;
  logic [DATA_BITS-1:0]  dat_q, dat_d;
  logic                  par_en_q, par_en_d;
  logic                  par_odd_q, par_odd_d;
  logic                  stop2_q, stop2_d;
  logic                  tx_q, tx_d;
  logic                  end_q, end_d;

  logic                  launch;
  logic [DATA_BITS-1:0]  launch_data;
  logic                  idle;

  assign idle = (state_q == IDLE);

`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_q, rd_q;
  logic [AW:0]          cnt_q;
  logic                 full, pop, push;

  assign full = (cnt_q == DEPTH_C);
  assign pop  = idle && (cnt_q != '0);
  // A full FIFO still takes a write in the cycle its head is popped.
  assign push = bus.tx_start && (!full || pop);

  assign launch      = pop;
  assign launch_data = mem[rd_q];

  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= bus.tx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign bus.tx_full = full;
  assign bus.tx_busy = !idle || (cnt_q != '0);
`else
  assign launch      = bus.tx_start && idle;
  assign launch_data = bus.tx_data;
  assign bus.tx_full = !idle;
  assign bus.tx_busy = !idle;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      div_q     <= '0;
      div_l_q   <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      dat_q     <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q   <= 1'b0;
      tx_q      <= 1'b1;
      end_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      div_l_q   <= div_l_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      dat_q     <= dat_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
      stop2_q   <= stop2_d;
      tx_q      <= tx_d;
      end_q     <= end_d;
    end
  end

  // tx is registered: the level computed here appears on the line the cycle after.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    div_l_d   = div_l_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    dat_d     = dat_q;
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    stop2_d   = stop2_q;
    tx_d      = tx_q;
    end_d     = 1'b0;

    if (idle) begin
      tx_d = 1'b1;
      if (launch) begin
        state_d   = START;
        sh_d      = launch_data;
        dat_d     = launch_data;
        div_d     = cfg_div;
        div_l_d   = cfg_div;
        par_en_d  = cfg_par_en;
        par_odd_d = cfg_par_odd;
        stop2_d   = cfg_stop2;
        bit_d     = '0;
        tx_d      = 1'b0;
      end
    end else if (div_q != '0) begin
      div_d = div_q - 1'b1;
    end else begin
      div_d = div_l_q;
      case (state_q)
        START: begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = sh_q[0];
        end
        DATA: begin
          if (bit_q == CW'(DATA_BITS - 1)) begin
            bit_d = '0;
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = (^dat_q) ^ par_odd_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
            sh_d  = sh_q >> 1;
            tx_d  = sh_q[1];
          end
        end
        PARITY: begin
          state_d = STOP;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
        STOP: begin
          tx_d = 1'b1;
          if (bit_q == {{(CW-1){1'b0}}, stop2_q}) begin
            state_d = IDLE;
            end_d   = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign tx         = tx_q;
  assign bus.tx_end = end_q;
endmodule
